// File: rtl/otter_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access size codes,
// default IO window base and the misalignment rule.
package otter_lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ST,
        RD0,
        CAP0,
        RD1,
        CAP1,
        DONE
    } lsu_state_e;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

    // An access is misaligned when its bytes spill past the end of the containing word.
    function automatic logic is_misaligned(input logic [1:0] offset, input logic [1:0] size);
        logic [3:0] span;
        span = {2'b00, offset} + (4'd1 << size);
        return span > 4'd4;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: selects the addressed bytes out of a two-word window and
// sign- or zero-extends them to 32 bits.
module lsu_load_align
    import otter_lsu_pkg::*;
(
    input  logic [31:0] word0_i,
    input  logic [31:0] word1_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = 32'({word1_i, word0_i} >> {offset_i, 3'b000});
        case (size_i)
            SIZE_BYTE: data_o = unsigned_i ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: data_o = unsigned_i ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default:   data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit for the memory data port: whole-word loads with local alignment,
// byte-split misaligned stores, and an aligned-word-only IO window.
module load_store_unit
    import otter_lsu_pkg::*;
#(
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    input  logic        REQ_WRITE,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] REQ_WDATA,
    input  logic [1:0]  REQ_SIZE,
    input  logic        REQ_SIGN,
    output logic        BUSY,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic        MEM_WRITE2,
    output logic        MEM_READ2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word0_q, word0_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_read_q, mem_read_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic        mem_sign_q, mem_sign_d;

    logic        req_err;
    logic        req_mis;
    logic        mis_q;
    logic [2:0]  n_stores;
    logic [31:0] word_addr;
    logic [31:0] align_word0;
    logic [31:0] load_data;

    assign req_err = (REQ_SIZE == SIZE_ILLEGAL) ||
                     ((REQ_ADDR >= IO_BASE) &&
                      !((REQ_SIZE == SIZE_WORD) && (REQ_ADDR[1:0] == 2'b00)));
    assign req_mis = is_misaligned(REQ_ADDR[1:0], REQ_SIZE);
    assign mis_q   = is_misaligned(addr_q[1:0], size_q);

    assign n_stores  = !mis_q ? 3'd1 : ((size_q == SIZE_HALF) ? 3'd2 : 3'd4);
    assign word_addr = {addr_q[31:2], 2'b00};

    // An aligned load finishes in CAP0, before word0 has been registered.
    assign align_word0 = (state_q == CAP0) ? MEM_DOUT2 : word0_q;

    lsu_load_align u_align (
        .word0_i    (align_word0),
        .word1_i    (MEM_DOUT2),
        .offset_i   (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (sign_q),
        .data_o     (load_data)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            word0_q     <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_size_q  <= '0;
            mem_sign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word0_q     <= word0_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_size_q  <= mem_size_d;
            mem_sign_q  <= mem_sign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        word0_d = word0_q;
        size_d  = size_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                    size_d  = REQ_SIZE;
                    sign_d  = REQ_SIGN;
                    cnt_d   = 3'd1;
                    if (req_err) begin
                        state_d = DONE;
                    end else if (REQ_WRITE) begin
                        state_d = ST;
                    end else begin
                        state_d = RD0;
                    end
                end
            end
            // cnt_q counts byte/word stores already issued.
            ST: begin
                if (cnt_q == n_stores) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RD0:  state_d = CAP0;
            CAP0: begin
                word0_d = MEM_DOUT2;
                state_d = mis_q ? RD1 : DONE;
            end
            RD1:  state_d = CAP1;
            CAP1: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Computes the next value of every registered output from the transition being taken.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_size_d  = mem_size_q;
        mem_sign_d  = mem_sign_q;
        unique case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (REQ_WRITE) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = REQ_ADDR;
                        if (req_mis) begin
                            mem_size_d = SIZE_BYTE;
                            mem_din_d  = {24'h0, REQ_WDATA[7:0]};
                        end else begin
                            mem_size_d  = REQ_SIZE;
                            mem_din_d   = REQ_WDATA;
                            rsp_valid_d = 1'b1;
                        end
                    end else begin
                        mem_read_d = 1'b1;
                        mem_addr_d = {REQ_ADDR[31:2], 2'b00};
                        mem_size_d = SIZE_WORD;
                        mem_sign_d = 1'b0;
                    end
                end
            end
            ST: begin
                if (cnt_q != n_stores) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = addr_q + 32'(cnt_q);
                    mem_size_d  = SIZE_BYTE;
                    mem_din_d   = {24'h0, wdata_q[{cnt_q[1:0], 3'b000} +: 8]};
                    rsp_valid_d = ((cnt_q + 3'd1) == n_stores);
                end
            end
            CAP0: begin
                if (mis_q) begin
                    mem_read_d = 1'b1;
                    mem_addr_d = word_addr + 32'd4;
                    mem_size_d = SIZE_WORD;
                    mem_sign_d = 1'b0;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data;
                end
            end
            CAP1: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_data;
            end
            default: ;
        endcase
    end

    assign BUSY       = (state_q != IDLE);
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_ERR    = rsp_err_q;
    assign RSP_RDATA  = rsp_rdata_q;
    assign MEM_ADDR2  = mem_addr_q;
    assign MEM_DIN2   = mem_din_q;
    assign MEM_WRITE2 = mem_write_q;
    assign MEM_READ2  = mem_read_q;
    assign MEM_SIZE   = mem_size_q;
    assign MEM_SIGN   = mem_sign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit: a transaction-level model schedules the expected
// per-cycle outputs and a single compare process checks them at every falling edge.
module tb_load_store_unit;

    localparam logic [31:0] IO_BASE = 32'h1100_0000;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ_VALID, REQ_WRITE, REQ_SIGN;
    logic [31:0] REQ_ADDR, REQ_WDATA;
    logic [1:0]  REQ_SIZE;
    logic        BUSY, RSP_VALID, RSP_ERR;
    logic [31:0] RSP_RDATA;
    logic [31:0] MEM_ADDR2, MEM_DIN2;
    logic        MEM_WRITE2, MEM_READ2, MEM_SIGN;
    logic [1:0]  MEM_SIZE;
    logic [31:0] MEM_DOUT2;

    int n_checks = 0;
    int n_errors = 0;

    // dmem is the memory the DUT talks to; mmem is the model's view of the same memory.
    logic [7:0] dmem [0:4095];
    logic [7:0] mmem [0:4095];
    logic       mem_init;
    logic [63:0] preload = 64'h8877_6655_4433_2211;

    logic        chk_en = 1'b0;
    logic        exp_busy, exp_valid, exp_err, exp_wr, exp_rd;
    logic [31:0] exp_addr, exp_din;
    logic [1:0]  exp_size;
    logic [31:0] model_rdata;

    load_store_unit #(
        .IO_BASE (IO_BASE)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .REQ_VALID  (REQ_VALID),
        .REQ_WRITE  (REQ_WRITE),
        .REQ_ADDR   (REQ_ADDR),
        .REQ_WDATA  (REQ_WDATA),
        .REQ_SIZE   (REQ_SIZE),
        .REQ_SIGN   (REQ_SIGN),
        .BUSY       (BUSY),
        .RSP_VALID  (RSP_VALID),
        .RSP_RDATA  (RSP_RDATA),
        .RSP_ERR    (RSP_ERR),
        .MEM_ADDR2  (MEM_ADDR2),
        .MEM_DIN2   (MEM_DIN2),
        .MEM_WRITE2 (MEM_WRITE2),
        .MEM_READ2  (MEM_READ2),
        .MEM_SIZE   (MEM_SIZE),
        .MEM_SIGN   (MEM_SIGN),
        .MEM_DOUT2  (MEM_DOUT2)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dword(input logic [11:0] ad);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = dmem[ad + 12'(b)];
        return w;
    endfunction

    // Memory responder: registered read data, byte-granular writes of 1 << MEM_SIZE bytes.
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) dmem[i] <= 8'h00;
            for (int b = 0; b < 8; b++) dmem[256 + b] <= preload[8*b +: 8];
            MEM_DOUT2 <= '0;
        end else begin
            if (MEM_WRITE2) begin
                for (int b = 0; b < 4; b++) begin
                    if (b < (1 << MEM_SIZE)) dmem[MEM_ADDR2[11:0] + 12'(b)] <= MEM_DIN2[8*b +: 8];
                end
            end
            if (MEM_READ2) MEM_DOUT2 <= dword(MEM_ADDR2[11:0]);
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busy", 32'(BUSY), 32'(exp_busy));
            chk("rsp_valid", 32'(RSP_VALID), 32'(exp_valid));
            chk("rsp_err", 32'(RSP_ERR), 32'(exp_err));
            chk("rsp_rdata", RSP_RDATA, model_rdata);
            chk("mem_write2", 32'(MEM_WRITE2), 32'(exp_wr));
            chk("mem_read2", 32'(MEM_READ2), 32'(exp_rd));
            if (exp_wr || exp_rd) begin
                chk("mem_addr2", MEM_ADDR2, exp_addr);
                chk("mem_size", 32'(MEM_SIZE), 32'(exp_size));
            end
            if (exp_wr) chk("mem_din2", MEM_DIN2, exp_din);
            if (exp_rd) chk("mem_sign", 32'(MEM_SIGN), 32'(1'b0));
        end
    end

    task automatic set_exp(input logic b, input logic v, input logic e, input logic w,
                           input logic r, input logic [31:0] ad, input logic [1:0] sz,
                           input logic [31:0] din);
        exp_busy  = b;
        exp_valid = v;
        exp_err   = e;
        exp_wr    = w;
        exp_rd    = r;
        exp_addr  = ad;
        exp_size  = sz;
        exp_din   = din;
        chk_en    = 1'b1;
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge, idle again.
    task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic sg, output logic [31:0] got);
        logic        err, mis, is_load;
        int          nb, len;
        logic [31:0] res, wbase;
        logic        s_wr [6];
        logic        s_rd [6];
        logic [31:0] s_addr [6];
        logic [1:0]  s_size [6];
        logic [31:0] s_din [6];
        for (int j = 0; j < 6; j++) begin
            s_wr[j] = 1'b0; s_rd[j] = 1'b0; s_addr[j] = '0; s_size[j] = '0; s_din[j] = '0;
        end
        nb      = 1 << sz;
        err     = (sz == 2'd3) || ((a >= IO_BASE) && !((sz == 2'd2) && (a[1:0] == 2'd0)));
        mis     = (int'(a[1:0]) + nb) > 4;
        is_load = !err && !wr;
        wbase   = {a[31:2], 2'b00};
        res     = '0;
        if (err) begin
            len = 1;
        end else if (wr) begin
            for (int k = 0; k < nb; k++) mmem[a[11:0] + 12'(k)] = wd[8*k +: 8];
            if (!mis) begin
                len = 1;
                s_wr[1] = 1'b1; s_addr[1] = a; s_size[1] = sz; s_din[1] = wd;
            end else begin
                len = nb;
                for (int k = 0; k < nb; k++) begin
                    s_wr[k+1] = 1'b1;
                    s_addr[k+1] = a + 32'(k);
                    s_size[k+1] = 2'd0;
                    s_din[k+1] = {24'h0, wd[8*k +: 8]};
                end
            end
        end else begin
            len = mis ? 5 : 3;
            s_rd[1] = 1'b1; s_addr[1] = wbase; s_size[1] = 2'd2;
            if (mis) begin
                s_rd[3] = 1'b1; s_addr[3] = wbase + 32'd4; s_size[3] = 2'd2;
            end
            for (int k = 0; k < nb; k++) res[8*k +: 8] = mmem[a[11:0] + 12'(k)];
            if (sz != 2'd2 && !sg && res[8*nb-1]) begin
                for (int k = nb; k < 4; k++) res[8*k +: 8] = 8'hFF;
            end
        end

        REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_ADDR = a; REQ_WDATA = wd;
        REQ_SIZE = sz; REQ_SIGN = sg;
        got = '0;
        for (int j = 1; j <= len; j++) begin
            @(posedge CLK);
            #1;
            if (j == len && (err || is_load)) model_rdata = res;
            set_exp(1'b1, j == len, err && (j == len), s_wr[j], s_rd[j], s_addr[j],
                    s_size[j], s_din[j]);
            @(negedge CLK);
            if (j == len) got = RSP_RDATA;
            // Requests while busy must be ignored.
            REQ_VALID = 1'($urandom); REQ_WRITE = 1'($urandom); REQ_ADDR = $urandom;
            REQ_WDATA = $urandom; REQ_SIZE = 2'($urandom); REQ_SIGN = 1'($urandom);
        end
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge CLK);
    endtask

    logic [31:0] got;
    logic [31:0] ra, rw;
    logic [1:0]  rs;
    logic        rwr, rsg;

    initial begin
        RST_N = 1'b0; mem_init = 1'b1;
        REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
        REQ_SIZE = '0; REQ_SIGN = 1'b0;
        for (int i = 0; i < 4096; i++) mmem[i] = 8'h00;
        for (int b = 0; b < 8; b++) mmem[256 + b] = preload[8*b +: 8];
        model_rdata = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1; mem_init = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge CLK);
        chk("rst_mem_addr2", MEM_ADDR2, 32'h0);
        chk("rst_mem_din2", MEM_DIN2, 32'h0);
        chk("rst_mem_size", 32'(MEM_SIZE), 32'h0);
        chk("rst_mem_sign", 32'(MEM_SIGN), 32'h0);

        run_txn(1'b0, 32'h100, '0, 2'd2, 1'b0, got); chk("lw_100", got, 32'h4433_2211);
        run_txn(1'b0, 32'h102, '0, 2'd2, 1'b0, got); chk("lw_102", got, 32'h6655_4433);
        run_txn(1'b0, 32'h106, '0, 2'd1, 1'b0, got); chk("lh_106", got, 32'hFFFF_8877);
        run_txn(1'b0, 32'h106, '0, 2'd1, 1'b1, got); chk("lhu_106", got, 32'h0000_8877);
        run_txn(1'b0, 32'h103, '0, 2'd0, 1'b0, got); chk("lb_103", got, 32'h0000_0044);
        run_txn(1'b1, 32'h101, 32'hDEAD_BEEF, 2'd2, 1'b0, got);
        run_txn(1'b0, 32'h100, '0, 2'd2, 1'b0, got); chk("sw_split_lo", got, 32'hADBE_EF11);
        run_txn(1'b0, 32'h104, '0, 2'd2, 1'b0, got); chk("sw_split_hi", got, 32'h8877_66DE);
        run_txn(1'b0, 32'h100, '0, 2'd3, 1'b0, got); chk("err_size3", got, 32'h0);
        run_txn(1'b0, 32'h1100_0002, '0, 2'd2, 1'b0, got); chk("err_io_mis", got, 32'h0);

        // Reset in the fourth cycle of a split load abandons it.
        REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = 32'h102; REQ_SIZE = 2'd2;
        REQ_SIGN = 1'b0;
        @(posedge CLK); #1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 2'd2, '0);
        @(negedge CLK); REQ_VALID = 1'b0;
        @(posedge CLK); #1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge CLK);
        @(posedge CLK); #1;
        RST_N = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 2'd2, '0);
        @(negedge CLK);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        model_rdata = '0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge CLK);
        chk("midrst_mem_addr2", MEM_ADDR2, 32'h0);
        run_txn(1'b0, 32'h100, '0, 2'd2, 1'b0, got); chk("lw_after_rst", got, 32'hADBE_EF11);

        for (int t = 0; t < 400; t++) begin
            rwr = 1'($urandom);
            rs  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra  = ($urandom_range(0, 9) == 0) ? IO_BASE + $urandom_range(0, 31)
                                              : 32'h100 + $urandom_range(0, 255);
            rw  = $urandom;
            rsg = 1'($urandom);
            run_txn(rwr, ra, rw, rs, rsg, got);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
                @(negedge CLK);
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h11000000, start of the memory-mapped IO region.
REQ-002 SHALL have ports CLK in 1, the single clock; RST_N in 1, synchronous active-low reset.
REQ-003 SHALL have REQ_VALID in 1, access request from the MEM stage; REQ_WRITE in 1, 1=store, 0=load.
REQ-004 SHALL have REQ_ADDR in 32, byte address; REQ_WDATA in 32, store data, little-endian.
REQ-005 SHALL have REQ_SIZE in 2, 0=byte, 1=half, 2=word, 3=illegal; REQ_SIGN in 1, 1=unsigned load.
REQ-006 SHALL have BUSY out 1, pipeline stall; RSP_VALID out 1, one-cycle completion pulse; RSP_RDATA out 32, load result; RSP_ERR out 1, error qualifier of RSP_VALID.
REQ-007 SHALL drive the data port of the dual-port memory: MEM_ADDR2 out 32; MEM_DIN2 out 32; MEM_WRITE2 out 1; MEM_READ2 out 1; MEM_SIZE out 2; MEM_SIGN out 1; MEM_DOUT2 in 32.

Function
REQ-008 SHALL accept a request only in IDLE when REQ_VALID=1 (cycle T), registering addr/data/size/sign/write; BUSY=1 in every non-IDLE state, and REQ_VALID while BUSY is ignored.
REQ-009 SHALL register all memory-side outputs; the memory read word is valid on MEM_DOUT2 the cycle after MEM_READ2.
REQ-010 SHALL classify an access as misaligned when addr[1:0] + (1<<size) > 4 (half at offset 3; word at offsets 1-3).
REQ-011 Aligned store: SHALL assert MEM_WRITE2 for exactly one cycle at T+1 with MEM_ADDR2=addr, MEM_SIZE=size, MEM_DIN2=wdata, and RSP_VALID in the same cycle.
REQ-012 Misaligned store: SHALL issue N byte stores (N=2 half, 4 word) in cycles T+1..T+N, store k at addr+k, MEM_SIZE=0, MEM_DIN2[7:0]=wdata byte k, other DIN bits 0; RSP_VALID in cycle T+N.
REQ-013 Loads: SHALL always read whole words (MEM_SIZE=2, MEM_SIGN=0, MEM_ADDR2={addr[31:2],2'b00}), performing extraction and extension locally.
REQ-014 Load FSM: IDLE -> RD0 (MEM_READ2=1) -> CAP0 (address held, MEM_READ2=0, word0 captured) -> [RD1 -> CAP1 at aligned addr+4 if misaligned] -> DONE (RSP_VALID=1) -> IDLE; the aligned result is at T+3, the misaligned result at T+5.
REQ-015 Load merge SHALL form {word1,word0}, shift right by 8*addr[1:0], take 8/16/32 bits, then sign-extend (REQ_SIGN=0) or zero-extend (REQ_SIGN=1); REQ_SIGN is ignored for words.
REQ-016 IO region (addr >= IO_BASE) SHALL allow only aligned word accesses: a single read/write cycle, no split; other IO accesses are errors.
REQ-017 Errors (size=3 or illegal IO) SHALL produce RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0 at T+1 with no MEM_READ2/MEM_WRITE2 assertion.
REQ-018 RSP_RDATA SHALL hold its last value until the next load completes; RSP_ERR=0 on every non-error response.
REQ-019 MEM_WRITE2 and MEM_READ2 SHALL never be asserted in the same cycle.

Reset
REQ-020 RST_N=0 at a clock edge SHALL force IDLE; BUSY, RSP_VALID, RSP_ERR, MEM_WRITE2 and MEM_READ2 go to 0; RSP_RDATA, MEM_ADDR2, MEM_DIN2, MEM_SIZE and MEM_SIGN go to 0.
REQ-021 Reset mid-operation SHALL abandon the access with no RSP_VALID; bytes of a split store already written remain written.

Structure
REQ-022 Package otter_lsu_pkg SHALL hold the FSM state enum (IDLE, ST, RD0, CAP0, RD1, CAP1, DONE), size encodings and the default IO_BASE.
REQ-023 Extraction/extension SHALL be one combinational sub-module, lsu_load_align.

Verification (memory preloaded with 0x100=0x44332211 and 0x104=0x88776655)
REQ-024 lw 0x100: one MEM_READ2 at 0x100, then RSP_VALID at T+3 with RSP_RDATA=0x44332211 and BUSY high for T+1..T+3.
REQ-025 lw 0x102: reads at 0x100 then 0x104, RSP_RDATA=0x66554433 at T+5; lh 0x106 gives 0xFFFF8877; lhu 0x106 gives 0x00008877; lb 0x103 gives 0x00000044.
REQ-026 sw 0xDEADBEEF at 0x101: four sb at 0x101-0x104 with DIN[7:0]=EF,BE,AD,DE; readback gives 0x100=0xADBEEF11 and 0x104=0x887766DE.
REQ-027 REQ_SIZE=3, or lw at 0x11000002: RSP_VALID=1 and RSP_ERR=1 at T+1, with no memory strobe.
REQ-028 RST_N=0 at T+3 of a misaligned load: IDLE next cycle with BUSY=0, no RSP_VALID, and a new request is accepted immediately.
